// File: rtl/multicycle_right_shifter.sv
// Iterative 32-bit right shifter, logical or arithmetic.
// Moves 2 bits per cycle, then 1 bit for an odd remainder.
module multicycle_right_shifter (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] in,
  input  logic [4:0]  shamt,
  input  logic        arith,
  output logic [31:0] out,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t     state;
  logic [4:0] count;
  logic       sign;

  // Accept a request in IDLE, shift down the remaining count, strobe done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= 5'd0;
      sign  <= 1'b0;
      out   <= 32'h0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            out   <= in;
            count <= shamt;
            sign  <= arith & in[31];
            if (shamt != 5'd0) begin
              state <= SHIFT;
            end else begin
              state <= DONE;
            end
          end
        end
        SHIFT: begin
          if (count >= 5'd2) begin
            out   <= {sign, sign, out[31:2]};
            count <= count - 5'd2;
            if (count == 5'd2) begin
              state <= DONE;
            end
          end else begin
            out   <= {sign, out[31:1]};
            count <= 5'd0;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Status is decoded from the state register only.
  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_multicycle_right_shifter.sv
// Directed and random bench for the iterative right shifter.
// Expected results go through a scoreboard queue.
module tb_multicycle_right_shifter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] in_d;
  logic [4:0]  shamt_d;
  logic        arith_d;
  logic [31:0] out;
  logic        busy;
  logic        done;

  int n_assert = 0;
  int n_fail = 0;
  logic [31:0] sb[$];

  multicycle_right_shifter dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .in    (in_d),
    .shamt (shamt_d),
    .arith (arith_d),
    .out   (out),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(logic [31:0] v, logic [4:0] s,
                                        logic a);
    logic [31:0] r;
    if (a) r = $unsigned($signed(v) >>> s);
    else   r = v >> s;
    return r;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one request; returns #1 after the accepting edge.
  task automatic launch(logic [31:0] v, logic [4:0] s, logic a);
    @(negedge clk);
    in_d    = v;
    shamt_d = s;
    arith_d = a;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    sb.push_back(model(v, s, a));
    in_d    = $urandom;
    shamt_d = 5'($urandom);
    arith_d = 1'($urandom);
  endtask

  // Next negedge is cycle k0 after the accept; wait for done (bounded).
  task automatic wait_done(string tag, int n_exp, int k0);
    int k;
    logic [31:0] exp;
    k = k0;
    @(negedge clk);
    while (!done && k < 40) begin
      check({tag, "_busy"}, 32'(busy), 32'd1);
      @(negedge clk);
      k++;
    end
    check({tag, "_lat"}, 32'(k), 32'(n_exp));
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_d"}, 32'(busy), 32'd1);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      exp = sb.pop_front();
      check({tag, "_out"}, out, exp);
    end
    @(negedge clk);
    check({tag, "_strobe"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_hold"}, out, exp);
  endtask

  initial begin
    logic [31:0] v;
    logic [4:0]  s;
    logic        a;
    reset   = 1'b1;
    start   = 1'b0;
    in_d    = 32'h0;
    shamt_d = 5'd0;
    arith_d = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out", out, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b0;

    launch(32'hF000_0000, 5'd2, 1'b0);
    wait_done("log2", 1, 0);
    launch(32'h0000_00FF, 5'd5, 1'b0);
    wait_done("odd5", 3, 0);
    launch(32'h8000_0000, 5'd31, 1'b1);
    wait_done("ar31", 16, 0);
    launch(32'h8000_0000, 5'd31, 1'b0);
    wait_done("lg31", 16, 0);
    launch(32'h7FFF_FFFF, 5'd31, 1'b1);
    wait_done("ar31p", 16, 0);
    launch(32'hDEAD_BEEF, 5'd0, 1'b1);
    wait_done("zero", 0, 0);

    // Start pulsed and then held while busy.
    launch(32'h0000_0100, 5'd8, 1'b0);
    @(negedge clk);
    in_d    = 32'hFFFF_FFFF;
    shamt_d = 5'd1;
    arith_d = 1'b0;
    start   = 1'b1;
    wait_done("busy1", 4, 1);
    @(posedge clk);
    #1;
    start = 1'b0;
    sb.push_back(model(32'hFFFF_FFFF, 5'd1, 1'b0));
    wait_done("busy2", 1, 0);

    // Asynchronous reset in the middle of a shift.
    launch(32'h8000_0000, 5'd20, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("arst_out", out, 32'h0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    void'(sb.pop_front());
    repeat (3) begin
      @(negedge clk);
      check("arst_nodone", 32'(done), 32'd0);
    end
    reset = 1'b0;
    launch(32'h0000_0010, 5'd4, 1'b0);
    wait_done("post_rst", 2, 0);

    for (int i = 0; i < 40; i++) begin
      v = $urandom;
      s = 5'($urandom);
      a = 1'($urandom);
      launch(v, s, a);
      wait_done("rand", (int'(s) + 1) / 2, 0);
    end

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
